// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the N-master Wishbone arbiter.
// The address/data width defaults below are overridden per instance through parameters.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEFAULT_ADDR_SIZE = 16;
    localparam int DEFAULT_WORD_SIZE = 8;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational one-hot picker: first asserted request at or after start, wrapping around.
module wb_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     winner
);

    logic found;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        // Upper segment [start, N) beats the wrapped segment [0, start).
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= start)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IDX_W'(i) < start)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_multi_arbiter.sv
// N-master Wishbone arbiter: fixed-priority or round-robin grant held for a whole transaction.
// Optional watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_multi_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int RR_MODE   = ARB_RR,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS*ADDR_SIZE-1:0] wb_addr_m,
    input  logic [N_MASTERS-1:0]           wb_cs_m,
    input  logic [N_MASTERS-1:0]           wb_we_m,
    input  logic [N_MASTERS*WORD_SIZE-1:0] wb_wdata_m,
    output logic [N_MASTERS*WORD_SIZE-1:0] wb_rdata_m,
    output logic [N_MASTERS-1:0]           wb_ack_m,
    output logic [N_MASTERS-1:0]           wb_err_m,
    output logic [ADDR_SIZE-1:0]           wb_addr,
    output logic                           wb_cs,
    output logic                           wb_we,
    output logic [WORD_SIZE-1:0]           wb_wdata,
    input  logic [WORD_SIZE-1:0]           wb_rdata,
    input  logic                           wb_ack,
    output logic [N_MASTERS-1:0]           grant,
    output logic                           busy
);

    localparam int IDX_W = $clog2(N_MASTERS);

    arb_state_t           state, state_next;
    logic [N_MASTERS-1:0] grant_q, winner;
    logic [IDX_W-1:0]     last_grant, start_idx, win_idx;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 sel_cs, sel_we, timeout_hit;

    // Fixed priority always searches from master 0.
    assign start_idx = (RR_MODE == ARB_RR)
                     ? ((last_grant == IDX_W'(N_MASTERS - 1)) ? '0 : last_grant + 1'b1)
                     : '0;

    wb_rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_picker (
        .req    (wb_cs_m),
        .start  (start_idx),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (winner[i]) win_idx = IDX_W'(i);
    end

    always_comb begin
        sel_addr  = '0;
        sel_cs    = 1'b0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                sel_addr  = wb_addr_m[i*ADDR_SIZE +: ADDR_SIZE];
                sel_cs    = wb_cs_m[i];
                sel_we    = wb_we_m[i];
                sel_wdata = wb_wdata_m[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog;

    // Held at zero outside BUSY, so it is already clear on entry.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY) wdog <= '0;
        else if (!wb_ack)         wdog <= wdog + 1'b1;
    end

    // A real ack in the same cycle wins over the timeout.
    assign timeout_hit = (state == BUSY) && sel_cs && !wb_ack && (wdog == WD_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_grant <= IDX_W'(N_MASTERS - 1);
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == BUSY) begin
                grant_q    <= winner;
                last_grant <= win_idx;
            end else if (state_next == IDLE) begin
                grant_q    <= '0;
            end
        end
    end

    // Ack, abort (cs dropped) or watchdog all end the transaction.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (|wb_cs_m) state_next = BUSY;
            BUSY: if (wb_ack || !sel_cs || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_addr    = '0;
        wb_cs      = 1'b0;
        wb_we      = 1'b0;
        wb_wdata   = '0;
        wb_ack_m   = '0;
        wb_err_m   = '0;
        wb_rdata_m = '0;
        if (state == BUSY) begin
            wb_addr  = sel_addr;
            wb_cs    = sel_cs;
            wb_we    = sel_we;
            wb_wdata = sel_wdata;
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant_q[i]) begin
                    // A reset in progress must not complete the owner's transfer.
                    wb_ack_m[i] = !rst && (wb_ack || timeout_hit);
                    wb_err_m[i] = !rst && timeout_hit;
                    if (!timeout_hit) wb_rdata_m[i*WORD_SIZE +: WORD_SIZE] = wb_rdata;
                end
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state == BUSY);

endmodule

// File: tb/tb_wb_multi_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter (4 masters each) against a
// transaction-level model; the timeout scenario follows `WB_ARB_TIMEOUT_EN.
module tb_wb_multi_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [N*AW-1:0] addr_m  [2];
    logic [N-1:0]    cs_m    [2];
    logic [N-1:0]    we_m    [2];
    logic [N*DW-1:0] wdata_m [2];
    logic [N*DW-1:0] rdata_m [2];
    logic [N-1:0]    ack_m   [2];
    logic [N-1:0]    err_m   [2];
    logic [AW-1:0]   addr    [2];
    logic            cs      [2];
    logic            we      [2];
    logic [DW-1:0]   wdata   [2];
    logic [DW-1:0]   rdata   [2];
    logic            ack     [2];
    logic [N-1:0]    grant   [2];
    logic            busy    [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner index (-1 = nobody), last winner, BUSY cycles elapsed in the current transfer.
    int           owner       [2];
    int           last        [2];
    int           busy_cycles [2];
    logic [N-1:0] exp_ack     [2];

    always #5 clk = ~clk;

    wb_multi_arbiter #(.N_MASTERS(N), .ADDR_SIZE(AW), .WORD_SIZE(DW), .RR_MODE(1), .TIMEOUT(TMO)) dut_rr (
        .clk(clk), .rst(rst),
        .wb_addr_m(addr_m[0]), .wb_cs_m(cs_m[0]), .wb_we_m(we_m[0]), .wb_wdata_m(wdata_m[0]),
        .wb_rdata_m(rdata_m[0]), .wb_ack_m(ack_m[0]), .wb_err_m(err_m[0]),
        .wb_addr(addr[0]), .wb_cs(cs[0]), .wb_we(we[0]), .wb_wdata(wdata[0]),
        .wb_rdata(rdata[0]), .wb_ack(ack[0]), .grant(grant[0]), .busy(busy[0])
    );

    wb_multi_arbiter #(.N_MASTERS(N), .ADDR_SIZE(AW), .WORD_SIZE(DW), .RR_MODE(0), .TIMEOUT(TMO)) dut_fx (
        .clk(clk), .rst(rst),
        .wb_addr_m(addr_m[1]), .wb_cs_m(cs_m[1]), .wb_we_m(we_m[1]), .wb_wdata_m(wdata_m[1]),
        .wb_rdata_m(rdata_m[1]), .wb_ack_m(ack_m[1]), .wb_err_m(err_m[1]),
        .wb_addr(addr[1]), .wb_cs(cs[1]), .wb_we(we[1]), .wb_wdata(wdata[1]),
        .wb_rdata(rdata[1]), .wb_ack(ack[1]), .grant(grant[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int d);
        int start;
        int i;
        start = (d == 0) ? (last[d] + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            i = (start + k) % N;
            if (cs_m[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        logic [N-1:0]       e_grant, e_ack, e_err;
        logic [N*DW-1:0]    e_rdata;
        logic [AW+DW+1:0]   e_down;
        logic               e_busy;
        bit                 to;
        int                 o;
        o       = owner[d];
        e_grant = '0; e_ack = '0; e_err = '0; e_rdata = '0; e_down = '0; e_busy = 1'b0; to = 1'b0;
        if (rst) begin
            check($sformatf("rst_ack%0d", d), ack_m[d], 0);
            check($sformatf("rst_err%0d", d), err_m[d], 0);
            owner[d]   = -1;
            last[d]    = N - 1;
            exp_ack[d] = '0;
            return;
        end
        if (o >= 0) begin
            to         = TO_EN && cs_m[d][o] && !ack[d] && (busy_cycles[d] == TMO);
            e_grant[o] = 1'b1;
            e_busy     = 1'b1;
            e_down     = {addr_m[d][o*AW +: AW], cs_m[d][o], we_m[d][o], wdata_m[d][o*DW +: DW]};
            e_ack[o]   = ack[d] | to;
            e_err[o]   = to;
            if (!to) e_rdata[o*DW +: DW] = rdata[d];
        end
        check($sformatf("grant%0d", d), grant[d], e_grant);
        check($sformatf("busy%0d", d),  busy[d],  e_busy);
        check($sformatf("down%0d", d),  {addr[d], cs[d], we[d], wdata[d]}, e_down);
        check($sformatf("ack_m%0d", d), ack_m[d], e_ack);
        check($sformatf("err_m%0d", d), err_m[d], e_err);
        check($sformatf("rdata_m%0d", d), rdata_m[d], e_rdata);
        exp_ack[d] = e_ack;
        if (o < 0) begin
            if (|cs_m[d]) begin
                owner[d]       = pick(d);
                last[d]        = owner[d];
                busy_cycles[d] = 1;
            end
        end else if (ack[d] || !cs_m[d][o] || to) begin
            owner[d] = -1;
        end else begin
            busy_cycles[d]++;
        end
    endtask

    task automatic eval();
        #1;
        for (int d = 0; d < 2; d++) model_step(d);
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++) begin
            addr_m[d] = '0; cs_m[d] = '0; we_m[d] = '0; wdata_m[d] = '0;
            rdata[d] = '0; ack[d] = 1'b0;
        end
    endtask

    task automatic set_req(input int d, input int i, input logic [AW-1:0] a,
                           input logic w, input logic [DW-1:0] wd);
        addr_m[d][i*AW +: AW]  = a;
        we_m[d][i]             = w;
        wdata_m[d][i*DW +: DW] = wd;
        cs_m[d][i]             = 1'b1;
    endtask

    task automatic drive_random(input int d);
        for (int i = 0; i < N; i++) begin
            if (cs_m[d][i] && exp_ack[d][i])             cs_m[d][i] = 1'b0;
            else if (cs_m[d][i])                         begin if ($urandom_range(99) < 3) cs_m[d][i] = 1'b0; end
            else if ($urandom_range(99) < 30)
                set_req(d, i, AW'($urandom), 1'($urandom_range(1)), DW'($urandom));
        end
        ack[d]   = ($urandom_range(99) < 35);
        rdata[d] = DW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit got;
        rst = 1'b1;
        clear_all();
        adv();
        repeat (3) cyc();
        rst = 1'b0;

        // Round-robin tie after reset: master 0 first, master 1 two cycles after the ack.
        set_req(0, 0, 16'h0100, 1'b0, 8'h00);
        set_req(0, 1, 16'h0200, 1'b1, 8'h33);
        eval(); check("rr_idle_first", grant[0], 0); check("busy_reset", busy[0], 0); adv();
        eval(); check("rr_tie_m0", grant[0], 4'b0001); adv();
        ack[0] = 1'b1; rdata[0] = 8'h5C;
        eval(); check("rr_ack0", ack_m[0], 4'b0001); check("rr_rdata0", rdata_m[0], 32'h0000_005C); adv();
        ack[0] = 1'b0; cs_m[0][0] = 1'b0;
        eval(); check("rr_gap", grant[0], 0); adv();
        eval(); check("rr_then_m1", grant[0], 4'b0010); adv();
        ack[0] = 1'b1; cyc();
        ack[0] = 1'b0; cs_m[0][1] = 1'b0; cyc();

        // Fixed priority: masters 0 and 2 always requesting, master 0 wins every time.
        set_req(1, 0, 16'h0A00, 1'b0, 8'h00);
        set_req(1, 2, 16'h0C00, 1'b1, 8'h77);
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                eval();
                if (busy[1]) got = 1'b1;
                else adv();
            end
            check("fx_wait_grant", got, 1);
            check("fx_grant_m0", grant[1], 4'b0001);
            adv();
            ack[1] = 1'b1; cyc(); ack[1] = 1'b0;
        end
        cs_m[1] = '0; cyc(); cyc();

        // Fresh reset, then write from master 1 with master 3 pending.
        rst = 1'b1; cyc(); rst = 1'b0;
        set_req(0, 1, 16'h0010, 1'b1, 8'hA5);
        set_req(0, 3, 16'h0030, 1'b0, 8'h00);
        cyc();
        eval();
        check("wr_grant_m1", grant[0], 4'b0010);
        check("wr_addr", addr[0], 16'h0010);
        check("wr_wdata", wdata[0], 8'hA5);
        check("wr_we", we[0], 1);
        adv();
        ack[0] = 1'b1;
        eval(); check("wr_ack_m1", ack_m[0][1], 1); check("wr_no_ack_m3", ack_m[0][3], 0); adv();
        ack[0] = 1'b0; cs_m[0][1] = 1'b0; cyc();
        eval(); check("wr_then_m3", grant[0], 4'b1000); adv();
        ack[0] = 1'b1; cyc();
        ack[0] = 1'b0; cs_m[0][3] = 1'b0; cyc();

        // Abort: owner drops cs in its second BUSY cycle; a late ack is not forwarded.
        set_req(0, 0, 16'h0044, 1'b0, 8'h00);
        cyc();
        eval(); check("ab_grant", grant[0], 4'b0001); adv();
        cs_m[0][0] = 1'b0;
        eval(); check("ab_cs_low", cs[0], 0); check("ab_still_busy", busy[0], 1); adv();
        ack[0] = 1'b1;
        eval(); check("ab_idle", grant[0], 0); check("ab_late_ack", ack_m[0], 0); adv();
        ack[0] = 1'b0;

        // Slave never acks.
        set_req(0, 0, 16'h0055, 1'b0, 8'h00);
        cyc();
        for (int b = 1; b <= TMO; b++) begin
            eval();
            if (b == TMO && TO_EN) begin
                check("to_ack", ack_m[0], 4'b0001);
                check("to_err", err_m[0], 4'b0001);
            end
            adv();
        end
`ifdef WB_ARB_TIMEOUT_EN
        cs_m[0][0] = 1'b0;
        eval(); check("to_idle", grant[0], 0); adv();
`else
        for (int b = TMO + 1; b <= 100; b++) cyc();
        eval(); check("no_to_busy", busy[0], 1); adv();
        ack[0] = 1'b1; cyc();
        ack[0] = 1'b0; cs_m[0][0] = 1'b0; cyc();
`endif

        // Reset in the middle of a transfer, then a round-robin tie goes to master 0.
        set_req(0, 2, 16'h0066, 1'b0, 8'h00);
        cyc();
        eval(); check("rb_grant_m2", grant[0], 4'b0100); adv();
        rst = 1'b1; ack[0] = 1'b1; cs_m[0] = '0;
        cyc();
        rst = 1'b0; ack[0] = 1'b0;
        set_req(0, 0, 16'h0001, 1'b0, 8'h00);
        set_req(0, 1, 16'h0002, 1'b0, 8'h00);
        eval(); check("rb_grant_zero", grant[0], 0); check("rb_busy_zero", busy[0], 0);
        check("rb_cs_zero", cs[0], 0); adv();
        eval(); check("rb_tie_m0", grant[0], 4'b0001); adv();
        ack[0] = 1'b1; cyc();
        ack[0] = 1'b0;

        // Randomized traffic on both arbiters.
        clear_all();
        cyc(); cyc();
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) drive_random(d);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
